// File: rtl/risc_probe_mux.sv
// risc_probe_mux: debug/display front end selecting memory, register or counter values onto a registered display bus
module risc_probe_mux #(
    parameter int DATA_W  = 32,
    parameter int OUT_W   = 16,
    parameter int ADDR_W  = 10,
    parameter int REFRESH = 1024,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            select,
    input  logic [ADDR_W-1:0]     inp,
    input  logic [(DATA_W/OUT_W > 1 ? $clog2(DATA_W/OUT_W) : 1)-1:0] slice,
    input  logic                  retire,
    input  logic                  halt,
    output logic                  dbg_req,
    output logic                  dbg_space,
    output logic [ADDR_W-1:0]     dbg_addr,
    input  logic                  dbg_valid,
    input  logic [DATA_W-1:0]     dbg_rdata,
    output logic [OUT_W-1:0]      out,
    output logic                  out_valid,
    output logic                  err
);
    localparam int RW = $clog2(REFRESH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state;
    logic [1:0]          sel_q;
    logic [ADDR_W-1:0]   inp_q;
    logic [RW-1:0]       rtmr;
    logic [TW-1:0]       tcnt;
    logic [DATA_W-1:0]   cyc_cnt, ret_cnt, word;
    logic                wvalid, werr, pending;
    logic                chg, trig, cmode;

    assign chg   = {select, inp} != {sel_q, inp_q};
    assign trig  = chg || (rtmr == RW'(REFRESH - 1));
    assign cmode = select[1];

    // free-running cycle and retired-instruction counters, frozen while halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else if (!halt) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (retire) ret_cnt <= ret_cnt + 1'b1;
        end
    end

    // shadow of select/inp and the periodic refresh timer, both feeding the trigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            inp_q <= '0;
            rtmr  <= '0;
        end else begin
            sel_q <= select;
            inp_q <= inp;
            rtmr  <= trig ? '0 : rtmr + 1'b1;
        end
    end

    // read handshake FSM and capture of the word to display
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dbg_req   <= 1'b0;
            dbg_space <= 1'b0;
            dbg_addr  <= '0;
            tcnt      <= '0;
            pending   <= 1'b0;
            word      <= '0;
            wvalid    <= 1'b0;
            werr      <= 1'b0;
        end else begin
            if (cmode) begin
                word   <= select[0] ? ret_cnt : cyc_cnt;
                wvalid <= 1'b1;
                werr   <= 1'b0;
            end else if (chg) begin
                wvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if ((trig || pending) && !cmode) begin
                        dbg_req   <= 1'b1;
                        dbg_addr  <= inp;
                        dbg_space <= select[0];
                        state     <= REQ;
                    end
                    pending <= 1'b0;
                end
                REQ: begin
                    dbg_req <= 1'b0;
                    tcnt    <= '0;
                    state   <= WAIT;
                    if (trig) pending <= 1'b1;
                end
                WAIT: begin
                    if (trig) pending <= 1'b1;
                    if (dbg_valid) begin
                        if (!cmode) begin
                            word   <= dbg_rdata;
                            wvalid <= 1'b1;
                            werr   <= 1'b0;
                        end
                        state <= IDLE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        if (!cmode) begin
                            werr   <= 1'b1;
                            wvalid <= 1'b0;
                        end
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // registered display slice and status, one cycle behind the captured word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            out       <= word[OUT_W*int'(slice) +: OUT_W];
            out_valid <= wvalid;
            err       <= werr;
        end
    end
endmodule

// File: tb/tb_risc_probe_mux.sv
// tb_risc_probe_mux: directed scoreboard bench for risc_probe_mux with a variable-latency debug memory model
module tb_risc_probe_mux;
    localparam int DATA_W  = 32;
    localparam int OUT_W   = 16;
    localparam int ADDR_W  = 10;
    localparam int REFRESH = 128;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        select = '0;
    logic [ADDR_W-1:0] inp = '0;
    logic              slice = 1'b0;
    logic              retire = 1'b0;
    logic              halt = 1'b0;
    logic              dbg_req, dbg_space;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_valid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [OUT_W-1:0]  out;
    logic              out_valid, err;

    int errors = 0, checks = 0, cyc = 0, req_cnt = 0, nvalid = 0, req_cyc = 0, lat = 3, cd = 0;
    bit answer = 1'b1, spur = 1'b0;
    logic              req_space_q = 1'b0;
    logic [ADDR_W-1:0] req_addr_q = '0;
    logic [DATA_W-1:0] exp_q[$];

    risc_probe_mux #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .REFRESH(REFRESH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .select(select), .inp(inp), .slice(slice), .retire(retire), .halt(halt),
        .dbg_req(dbg_req), .dbg_space(dbg_space), .dbg_addr(dbg_addr), .dbg_valid(dbg_valid),
        .dbg_rdata(dbg_rdata), .out(out), .out_valid(out_valid), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] model(input logic sp, input logic [ADDR_W-1:0] a);
        if (sp) return (a[4:0] == 5'd3) ? 32'h0000_0055 : (32'h0F00_0000 | 32'(a[4:0]));
        return (a == ADDR_W'(5)) ? 32'h1234_ABCD : (32'hC0DE_0000 | 32'(a));
    endfunction

    // debug port model: answers each request lat negedges after it is seen
    initial begin
        dbg_valid = 1'b0;
        dbg_rdata = '0;
        forever begin
            @(negedge clk);
            dbg_valid = 1'b0;
            if (rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        dbg_valid = 1'b1;
                        dbg_rdata = model(req_space_q, req_addr_q);
                        nvalid++;
                    end
                end
                if (spur) begin
                    dbg_valid = 1'b1;
                    dbg_rdata = 32'hDEAD_BEEF;
                end
                if (dbg_req) begin
                    req_cnt++;
                    req_cyc     = cyc;
                    req_space_q = dbg_space;
                    req_addr_q  = dbg_addr;
                    if (answer) cd = lat;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input logic [1:0] s, input logic [ADDR_W-1:0] a);
        select = s;
        inp    = a;
        exp_q.push_back(model(s[0], a));
    endtask

    task automatic wait_req(input int n0, input string tag);
        int i = 0;
        while (req_cnt == n0 && i < 64) begin
            tick();
            i++;
        end
        check({tag, "_req_seen"}, 64'(req_cnt > n0), 64'd1);
    endtask

    task automatic expect_read(input string tag);
        int n0 = nvalid;
        int i = 0;
        logic [DATA_W-1:0] w;
        while (nvalid == n0 && i < 64) begin
            tick();
            i++;
        end
        check({tag, "_valid_seen"}, 64'(nvalid > n0), 64'd1);
        tick();
        w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_out"}, 64'(out), 64'(slice ? w[31:16] : w[15:0]));
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        int n, r1, i;
        tick(2);
        check("rst_out", 64'(out), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_dbg_req", 64'(dbg_req), 64'd0);
        check("rst_dbg_space", 64'(dbg_space), 64'd0);
        check("rst_dbg_addr", 64'(dbg_addr), 64'd0);
        rst = 1'b0;
        tick(2);
        n = req_cnt;
        probe(2'd0, ADDR_W'(5));
        expect_read("mem5");
        check("mem5_one_pulse", 64'(req_cnt - n), 64'd1);
        check("mem5_addr", 64'(req_addr_q), 64'd5);
        check("mem5_space", 64'(req_space_q), 64'd0);
        slice = 1'b1;
        tick();
        check("mem5_slice1", 64'(out), 64'h1234);
        slice = 1'b0;
        tick(2);
        probe(2'd1, ADDR_W'(3));
        expect_read("reg3");
        check("reg3_space", 64'(req_space_q), 64'd1);
        check("reg3_addr", 64'(req_addr_q), 64'd3);
        r1 = req_cyc;
        n  = req_cnt;
        i  = 0;
        while (req_cnt == n && i < REFRESH + 40) begin
            tick();
            i++;
        end
        check("refresh_period", 64'(req_cyc - r1), 64'(REFRESH));
        tick(8);
        answer = 1'b0;
        select = 2'd0;
        inp    = ADDR_W'(9);
        i = 0;
        while (err !== 1'b1 && i < 64) begin
            tick();
            i++;
        end
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_out_valid", 64'(out_valid), 64'd0);
        check("timeout_out_kept", 64'(out), 64'h0055);
        answer = 1'b1;
        tick(2);
        probe(2'd0, ADDR_W'(5));
        expect_read("recover");
        lat = 4;
        n = req_cnt;
        probe(2'd0, ADDR_W'(8));
        wait_req(n, "mem8");
        r1 = req_cnt;
        tick();
        probe(2'd0, ADDR_W'(6));
        expect_read("mem8");
        wait_req(r1, "mem6");
        check("mem6_addr", 64'(req_addr_q), 64'd6);
        expect_read("mem6");
        lat = 10;
        n = req_cnt;
        select = 2'd0;
        inp    = ADDR_W'(7);
        wait_req(n, "rst_mid");
        tick(2);
        rst = 1'b1;
        #1;
        check("rst_mid_out", 64'(out), 64'd0);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_err", 64'(err), 64'd0);
        check("rst_mid_dbg_req", 64'(dbg_req), 64'd0);
        exp_q.delete();
        select = 2'd0;
        inp    = '0;
        halt   = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        tick(3);
        check("spurious_out_valid", 64'(out_valid), 64'd0);
        check("spurious_out", 64'(out), 64'd0);
        select = 2'd2;
        tick(3);
        check("cyc_after_rst", 64'(out), 64'd0);
        check("cyc_out_valid", 64'(out_valid), 64'd1);
        halt = 1'b0;
        tick(100);
        halt = 1'b1;
        tick(3);
        check("cyc_100", 64'(out), 64'd100);
        tick(17);
        check("cyc_frozen", 64'(out), 64'd100);
        halt = 1'b0;
        repeat (7) begin
            retire = 1'b1;
            tick();
            retire = 1'b0;
            tick();
        end
        halt   = 1'b1;
        select = 2'd3;
        tick(3);
        check("ret_7", 64'(out), 64'd7);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
